router_out_arb: RTL and testbench
=================================

# router_out_arb

Clocked round-robin arbiter that shares one router output channel among up to five input requesters (PE, N, E, W, S). Each requester offers one 35-bit packet with a valid/ready handshake. The arbiter grants one requester per transfer into a single-entry output register, which drives the downstream link or channel adapter. It sits between the per-input direction-decode stages and one output direction of a NoC router node.

## Interface
- WIDTH, 35, packet width; header fields are src_x [WIDTH-1:WIDTH-2], src_y [WIDTH-3:WIDTH-4], dst_x [WIDTH-5:WIDTH-6], dst_y [WIDTH-7:WIDTH-8]; the arbiter does not modify them.
- NREQ, 5, number of requesters; index 0=PE, 1=N, 2=E, 3=W, 4=S.
- CNTW, 16, width of the delivered-packet counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  NREQ  bit i set when requester i offers a packet.
- in_data  in  NREQ*WIDTH  packet from requester i in bits [i*WIDTH +: WIDTH].
- in_ready  out  NREQ  one-hot or zero; bit i high means requester i's packet is accepted this cycle.
- out_valid  out  1  output register holds a packet.
- out_data  out  WIDTH  held packet.
- out_ready  in  1  downstream accepts out_data this cycle.
- grant_id  out  3  index of the requester whose packet is in the output register.
- pkt_count  out  CNTW  number of packets delivered downstream (out_valid & out_ready), modulo 2^CNTW.

## Operation
- The arbiter has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = (state==EMPTY) | out_ready.
  - A FULL register draining this cycle may reload in the same cycle.
- Arbitration is combinational over in_valid and uses last_grant (register, 0..NREQ-1).
  - Search order: last_grant+1, last_grant+2, …, wrapping modulo NREQ, ending at last_grant itself.
  - The first set in_valid bit in that order wins.
- in_ready[i] = load_en & (i == winner) & in_valid[i]. At most one bit is set. in_ready is never asserted when no in_valid bit is set.
- On an accept (any in_ready bit set) at a clock edge:
  - out_data ← in_data[winner]
  - grant_id ← winner
  - last_grant ← winner
  - state ← FULL
- On a drain without an accept: state ← EMPTY. out_data and grant_id keep their last values.
- FULL with out_ready=0: out_data, grant_id and out_valid are held stable. No requester is accepted.
- pkt_count increments on every cycle with out_valid & out_ready, and wraps from 2^CNTW-1 to 0.
- Fairness: a continuously valid requester is granted within NREQ-1 other grants.
- The arbiter assumes a requester holds in_valid and in_data stable until accepted. It does not check this.

## Timing
- Reset values:
  - state=EMPTY, so out_valid=0
  - out_data=0
  - grant_id=0
  - pkt_count=0
  - last_grant=NREQ-1, so requester 0 wins first
  - in_ready=0 while reset is high
- Latency: a packet accepted at edge t is visible on out_data/out_valid after edge t. Downstream can take it in the same cycle.
- Throughput: one packet per cycle while out_ready stays high and requests are present.
- in_ready depends combinationally on in_valid, out_ready, state and last_grant. There is no combinational path from in_data.
- A simultaneous drain and accept in one cycle keeps out_valid=1 with no bubble. pkt_count and the output register both update at that edge.
- Reset asserted mid-transfer:
  - The held packet is discarded, and the counters and pointer return to their reset values.
  - in_ready drops without waiting for a clock.
  - The first edge after deassertion may accept a packet.
- Edge case NREQ=1: last_grant is always 0. The block degenerates to a one-entry pipeline register.

## Test plan
- Reset, then in_valid=5'b00100 with in_data[2]=35'h4_8000_0001 and out_ready=1 → in_ready=5'b00100 in that cycle. Next cycle out_valid=1, out_data=35'h4_8000_0001, grant_id=2. pkt_count=1 after the drain edge.
- All five requesters valid continuously, out_ready=1 → grant_id sequence 0,1,2,3,4,0,… over 10 cycles with no idle cycle. pkt_count reaches 10.
- Requester 3 granted, then out_ready=0 for 4 cycles with all requesters valid → out_data and grant_id stay at 3 and in_ready=0 throughout. When out_ready rises, the next grant is 4, in the same cycle as the drain.
- Only requesters 1 and 4 valid, last_grant=4 → grants alternate 1,4,1,4. Requester 0 is never granted and in_ready[0,2,3] stays 0.
- Assert reset while FULL with out_ready=0 → out_valid falls to 0 and in_ready to 0 immediately, with no edge needed. After release, with all requesters valid, the first grant is 0.
- Preload pkt_count near 2^16-1 by running 65535 drains, then 2 more → pkt_count reads 65535 then 0, then 1.

Source files
------------

// File: rtl/router_out_arb_if.sv
// Bundle of the five-way request side and the single output channel of one
// router output port arbiter.
interface router_out_arb_if #(
  parameter int WIDTH = 35,
  parameter int NREQ  = 5,
  parameter int CNTW  = 16
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. A producer holds valid and data stable until that edge, and
  // ready may depend combinationally on valid but never on data.
  logic [NREQ-1:0]       in_valid;
  logic [NREQ*WIDTH-1:0] in_data;
  logic [NREQ-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [2:0]            grant_id;
  logic [CNTW-1:0]       pkt_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, grant_id, pkt_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, grant_id, pkt_count
  );
endinterface

// File: rtl/router_out_arb.sv
// Round-robin arbiter sharing one NoC output channel among up to five
// requesters, feeding a single-entry output register.
module router_out_arb #(
  parameter int WIDTH = 35,
  parameter int NREQ  = 5,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  router_out_arb_if.slave   bus,
  output logic              state_dbg_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [2:0]        last_grant_q, last_grant_d;
  logic [2:0]        grant_id_q, grant_id_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CNTW-1:0]   pkt_count_q, pkt_count_d;

  logic [2:0]        winner;
  logic              any_valid;
  logic              load_en;
  logic              accept;
  logic              drain;
  logic [NREQ-1:0]   in_ready;
  int                idx;

  // Search starts just after the last winner and ends on it, so the most
  // recently served requester has the lowest priority.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_q) + k) % NREQ;
      if (!any_valid && bus.in_valid[idx]) begin
        any_valid = 1'b1;
        winner    = 3'(idx);
      end
    end
  end

  assign load_en = (state_q == EMPTY) | bus.out_ready;
  assign drain   = (state_q == FULL) & bus.out_ready;

  // Reset gates ready directly so requesters see it drop without a clock.
  always_comb begin
    in_ready = '0;
    if (!reset && load_en && any_valid) begin
      in_ready[winner] = 1'b1;
    end
  end

  assign accept = |in_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    out_data_d   = out_data_q;
    pkt_count_d  = pkt_count_q;
    if (drain) begin
      pkt_count_d = pkt_count_q + 1'b1;
    end
    if (accept) begin
      state_d      = FULL;
      last_grant_d = winner;
      grant_id_d   = winner;
      out_data_d   = bus.in_data[int'(winner)*WIDTH +: WIDTH];
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      last_grant_q <= 3'(NREQ-1);
      grant_id_q   <= '0;
      out_data_q   <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      out_data_q   <= out_data_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.pkt_count = pkt_count_q;
  assign state_dbg_o   = (state_q == FULL);

endmodule

// File: tb/tb_router_out_arb.sv
// Directed bench for router_out_arb: a table of per-cycle vectors plus
// hand-written sequences for mid-transfer reset and counter wrap.
module tb_router_out_arb;
  localparam int WIDTH = 35;
  localparam int NREQ  = 5;
  localparam int CNTW  = 16;
  localparam int NVEC  = 26;

  logic clk;
  logic reset;
  logic state_dbg;

  router_out_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) bus ();

  router_out_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic        do_rst;
    logic [4:0]  iv;
    logic        ordy;
    logic [4:0]  exp_ir;
    logic        exp_ov;
    logic [2:0]  exp_gid;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic logic [WIDTH-1:0] pkt(input int i);
    logic [WIDTH-1:0] base;
    base = 35'h0_1234_5600;
    if (i == 2) return 35'h4_8000_0001;
    return base + WIDTH'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 5'b11111;
    #1;
    check("rst_in_ready_held", 64'(bus.in_ready), 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 5'b00000;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_grant_id", 64'(bus.grant_id), 64'h0);
    check("rst_pkt_count", 64'(bus.pkt_count), 64'h0);
    check("rst_out_data", 64'(bus.out_data), 64'h0);
    check("rst_state_dbg", 64'(state_dbg), 64'h0);
    exp_q.delete();
  endtask

  task automatic set_vec(input int n, input logic r, input logic [4:0] iv, input logic o,
                         input logic [4:0] ir, input logic ov, input logic [2:0] g,
                         input logic [15:0] c);
    vecs[n] = '{do_rst: r, iv: iv, ordy: o, exp_ir: ir, exp_ov: ov, exp_gid: g, exp_cnt: c};
  endtask

  task automatic apply_vec(input int n);
    logic [WIDTH-1:0] e;
    if (vecs[n].do_rst) do_reset();
    @(negedge clk);
    bus.in_valid  = vecs[n].iv;
    bus.out_ready = vecs[n].ordy;
    #1;
    check($sformatf("v%0d_in_ready", n), 64'(bus.in_ready), 64'(vecs[n].exp_ir));
    check($sformatf("v%0d_out_valid", n), 64'(bus.out_valid), 64'(vecs[n].exp_ov));
    check($sformatf("v%0d_grant_id", n), 64'(bus.grant_id), 64'(vecs[n].exp_gid));
    check($sformatf("v%0d_pkt_count", n), 64'(bus.pkt_count), 64'(vecs[n].exp_cnt));
    if (vecs[n].exp_ov)
      check($sformatf("v%0d_out_data", n), 64'(bus.out_data), 64'(pkt(int'(vecs[n].exp_gid))));
    // scoreboard: drained packet leaves before this cycle's accepted one enters
    if (vecs[n].exp_ov && vecs[n].ordy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL v%0d_sb_empty: got drain expected none", n);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_sb_data", n), 64'(bus.out_data), 64'(e));
      end
    end
    for (int b = 0; b < NREQ; b++)
      if (vecs[n].exp_ir[b]) exp_q.push_back(pkt(b));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- test ----------------
  initial begin
    reset         = 1'b1;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) bus.in_data[i*WIDTH +: WIDTH] = pkt(i);

    //          rst  in_valid  ordy exp_ir    ov gid cnt
    set_vec(0,  1, 5'b00100, 1, 5'b00100, 0, 0, 0);
    set_vec(1,  0, 5'b00000, 1, 5'b00000, 1, 2, 0);
    set_vec(2,  0, 5'b00000, 1, 5'b00000, 0, 2, 1);
    set_vec(3,  1, 5'b11111, 1, 5'b00001, 0, 0, 0);
    set_vec(4,  0, 5'b11111, 1, 5'b00010, 1, 0, 0);
    set_vec(5,  0, 5'b11111, 1, 5'b00100, 1, 1, 1);
    set_vec(6,  0, 5'b11111, 1, 5'b01000, 1, 2, 2);
    set_vec(7,  0, 5'b11111, 1, 5'b10000, 1, 3, 3);
    set_vec(8,  0, 5'b11111, 1, 5'b00001, 1, 4, 4);
    set_vec(9,  0, 5'b11111, 1, 5'b00010, 1, 0, 5);
    set_vec(10, 0, 5'b11111, 1, 5'b00100, 1, 1, 6);
    set_vec(11, 0, 5'b11111, 1, 5'b01000, 1, 2, 7);
    set_vec(12, 0, 5'b11111, 1, 5'b10000, 1, 3, 8);
    set_vec(13, 0, 5'b01000, 1, 5'b01000, 1, 4, 9);
    set_vec(14, 0, 5'b11111, 0, 5'b00000, 1, 3, 10);
    set_vec(15, 0, 5'b11111, 0, 5'b00000, 1, 3, 10);
    set_vec(16, 0, 5'b11111, 0, 5'b00000, 1, 3, 10);
    set_vec(17, 0, 5'b11111, 0, 5'b00000, 1, 3, 10);
    set_vec(18, 0, 5'b11111, 1, 5'b10000, 1, 3, 10);
    set_vec(19, 0, 5'b00000, 1, 5'b00000, 1, 4, 11);
    set_vec(20, 0, 5'b10010, 1, 5'b00010, 0, 4, 12);
    set_vec(21, 0, 5'b10010, 1, 5'b10000, 1, 1, 12);
    set_vec(22, 0, 5'b10010, 1, 5'b00010, 1, 4, 13);
    set_vec(23, 0, 5'b10010, 1, 5'b10000, 1, 1, 14);
    set_vec(24, 0, 5'b00000, 1, 5'b00000, 1, 4, 15);
    set_vec(25, 0, 5'b00000, 1, 5'b00000, 0, 4, 16);

    for (int n = 0; n < NVEC; n++) apply_vec(n);

    // reset while FULL and stalled: outputs must clear with no clock edge
    @(negedge clk);
    bus.in_valid  = 5'b11111;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid_pre_out_valid", 64'(bus.out_valid), 64'h1);
    check("mid_pre_grant_id", 64'(bus.grant_id), 64'h0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_out_valid", 64'(bus.out_valid), 64'h0);
    check("mid_in_ready", 64'(bus.in_ready), 64'h0);
    check("mid_out_data", 64'(bus.out_data), 64'h0);
    check("mid_pkt_count", 64'(bus.pkt_count), 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("post_in_ready", 64'(bus.in_ready), 64'h01);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("post_grant_id", 64'(bus.grant_id), 64'h0);
    check("post_out_valid", 64'(bus.out_valid), 64'h1);
    check("post_out_data", 64'(bus.out_data), 64'(pkt(0)));

    // counter wrap: 65536 edges give one accept then 65535 drains
    do_reset();
    @(negedge clk);
    bus.in_valid  = 5'b00001;
    bus.out_ready = 1'b1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    #1;
    check("wrap_max", 64'(bus.pkt_count), 64'hFFFF);
    check("wrap_out_valid", 64'(bus.out_valid), 64'h1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("wrap_zero", 64'(bus.pkt_count), 64'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("wrap_one", 64'(bus.pkt_count), 64'h1);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
